// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared widths, FSM state types and counter sizing for the display RAM port sequencer
package ram_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ARM,
        W_ISSUE,
        W_REL
    } wr_state_t;

    typedef enum logic {
        R_SCAN,
        R_HOLD
    } rd_state_t;

    // Counter width able to hold 0..n; never narrower than one bit so a zero
    // count parameter still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - switch synchroniser, press/release debounce and single-cycle pulse
module sw_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_in,
    output logic fire,
    output logic pulse
);

    import ram_pkg::*;

    localparam int CNT_W = cnt_width(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_q;
    logic             req_s;
    wr_state_t        state;
    wr_state_t        state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    // Two-flop synchroniser for the asynchronous switch.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b0;
            req_s  <= 1'b0;
        end else begin
            sync_q <= sw_in;
            req_s  <= sync_q;
        end
    end

    // State and debounce counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= W_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: press must be stable DEBOUNCE_CYC samples, release likewise.
    // fire marks the capture cycle (last stable sample), pulse is the write cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        fire     = 1'b0;
        pulse    = 1'b0;
        case (state)
            W_IDLE: begin
                if (req_s) begin
                    // The sample seen here is the first stable one.
                    if (DEBOUNCE_CYC == 1) begin
                        state_nx = W_ISSUE;
                        fire     = 1'b1;
                    end else begin
                        state_nx = W_ARM;
                        cnt_nx   = CNT_ONE;
                    end
                end
            end
            W_ARM: begin
                if (!req_s) begin
                    state_nx = W_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nx = W_ISSUE;
                    fire     = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            W_ISSUE: begin
                pulse    = 1'b1;
                state_nx = W_REL;
                cnt_nx   = '0;
            end
            W_REL: begin
                // Any high sample restarts the release window, so a held
                // or bouncing switch never re-arms.
                if (req_s) begin
                    cnt_nx = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = W_IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = W_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: rtl/ram_port_sequencer.sv
// rtl/ram_port_sequencer.sv - write/read port sequencing for the 32x4 display RAM
module ram_port_sequencer #(
    parameter int ADDR_W       = ram_pkg::ADDR_W,
    parameter int DATA_W       = ram_pkg::DATA_W,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int HOLD_TICKS   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [DATA_W-1:0] wr_data_in,
    input  logic              tick,
    output logic              wren,
    output logic [ADDR_W-1:0] wraddress,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              wrap,
    output logic              holding
);

    import ram_pkg::*;

    localparam int HC_W = cnt_width(HOLD_TICKS);
    localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

    logic              capture;
    logic              tick_q;
    logic              tick_rise;
    rd_state_t         rd_state;
    rd_state_t         rd_state_nx;
    logic [ADDR_W-1:0] rdaddress_nx;
    logic              wrap_nx;
    logic              holding_nx;
    logic [HC_W-1:0]   hold_cnt;
    logic [HC_W-1:0]   hold_cnt_nx;

    sw_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_wr_debounce (
        .clk   (clk),
        .reset (reset),
        .sw_in (wr_req_in),
        .fire  (capture),
        .pulse (wren)
    );

    // Tick is a level; only its rising edge advances the read side.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick;
        end
    end

    assign tick_rise = tick & ~tick_q;

    // Capture the switch buses once the request is debounced; held until the next write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wraddress <= '0;
            data      <= '0;
        end else if (capture) begin
            wraddress <= wr_addr_in;
            data      <= wr_data_in;
        end
    end

    // Read FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state  <= R_SCAN;
            rdaddress <= '0;
            wrap      <= 1'b0;
            holding   <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            rd_state  <= rd_state_nx;
            rdaddress <= rdaddress_nx;
            wrap      <= wrap_nx;
            holding   <= holding_nx;
            hold_cnt  <= hold_cnt_nx;
        end
    end

    // Read FSM next state: scan on ticks, park on a fresh write, resume after the hold.
    // Hold entry lands on the edge that starts the wren cycle, so the read port
    // already shows the written location while wren is high; a tick rising in
    // the capture or wren cycle is dropped.
    always_comb begin
        rd_state_nx  = rd_state;
        rdaddress_nx = rdaddress;
        wrap_nx      = wrap;
        holding_nx   = holding;
        hold_cnt_nx  = hold_cnt;
        if ((HOLD_TICKS > 0) && capture) begin
            rd_state_nx  = R_HOLD;
            rdaddress_nx = wr_addr_in;
            hold_cnt_nx  = '0;
            holding_nx   = 1'b1;
        end else begin
            case (rd_state)
                R_SCAN: begin
                    if (tick_rise) begin
                        rdaddress_nx = rdaddress + 1'b1;
                        if (rdaddress == ADDR_MAX) begin
                            wrap_nx = ~wrap;
                        end
                    end
                end
                R_HOLD: begin
                    if (tick_rise && !wren) begin
                        if (hold_cnt == HOLD_LAST) begin
                            // Resume past the written cell; the page bit is
                            // not toggled by this jump even from the top address.
                            rd_state_nx  = R_SCAN;
                            rdaddress_nx = wraddress + 1'b1;
                            holding_nx   = 1'b0;
                        end else begin
                            hold_cnt_nx = hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    rd_state_nx = R_SCAN;
                    holding_nx  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_sequencer.sv
// tb/tb_ram_port_sequencer.sv - directed self-checking bench for ram_port_sequencer
module tb_ram_port_sequencer;

    logic       clk;
    logic       reset;
    logic       wr_req_in;
    logic [4:0] wr_addr_in;
    logic [3:0] wr_data_in;
    logic       tick;
    logic       wren;
    logic [4:0] wraddress;
    logic [3:0] data;
    logic [4:0] rdaddress;
    logic       wrap;
    logic       holding;

    int checks;
    int errors;
    int wren_count;
    logic model_wrap;

    typedef struct {
        logic [4:0] addr;
        logic [3:0] data;
        int         high_cycles;
        bit         bounce;
    } wr_vec_t;

    typedef struct {
        int         width;
        logic [4:0] exp_rd;
        logic       exp_wrap;
    } tick_vec_t;

    wr_vec_t   wr_tab [3];
    tick_vec_t tk_tab [3];

    ram_port_sequencer #(
        .ADDR_W      (5),
        .DATA_W      (4),
        .DEBOUNCE_CYC(4),
        .HOLD_TICKS  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_req_in  (wr_req_in),
        .wr_addr_in (wr_addr_in),
        .wr_data_in (wr_data_in),
        .tick       (tick),
        .wren       (wren),
        .wraddress  (wraddress),
        .data       (data),
        .rdaddress  (rdaddress),
        .wrap       (wrap),
        .holding    (holding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wren === 1'b1) wren_count++;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual running required finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick_pulse(input int w);
        @(posedge clk); #1 tick = 1'b1;
        repeat (w) @(posedge clk);
        #1 tick = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [3:0] d, input int high_cycles,
                            input bit bounce, input bit tick_at_wren, input string tag);
        int base;
        @(posedge clk); #1;
        wr_addr_in = a;
        wr_data_in = d;
        wr_req_in  = 1'b1;
        base       = wren_count;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            if (k == 6 && tick_at_wren) begin
                #1 tick = 1'b1;
            end
            @(negedge clk);
            if (k == 5) check({tag, "_wren_early"}, wren, 1'b0);
            if (k == 6) begin
                check({tag, "_wren"}, wren, 1'b1);
                check({tag, "_wraddress"}, wraddress, a);
                check({tag, "_data"}, data, d);
                check({tag, "_rd_at_wren"}, rdaddress, a);
                check({tag, "_holding_at_wren"}, holding, 1'b1);
            end
        end
        wr_addr_in = ~a;
        wr_data_in = ~d;
        repeat (high_cycles - 6) @(posedge clk);
        #1;
        wr_req_in = 1'b0;
        tick      = 1'b0;
        if (bounce) begin
            for (int b = 0; b < 3; b++) begin
                repeat (2) @(posedge clk);
                #1 wr_req_in = 1'b1;
                @(posedge clk);
                #1 wr_req_in = 1'b0;
            end
        end
        repeat (14) @(posedge clk);
        @(negedge clk);
        check({tag, "_wren_count"}, wren_count - base, 1);
        check({tag, "_wraddress_held"}, wraddress, a);
        check({tag, "_data_held"}, data, d);
        check({tag, "_still_parked"}, {holding, rdaddress}, {1'b1, a});
    endtask

    initial begin
        logic [4:0] nxt;
        int base;
        checks     = 0;
        errors     = 0;
        wren_count = 0;
        reset      = 1'b1;
        wr_req_in  = 1'b0;
        wr_addr_in = '0;
        wr_data_in = '0;
        tick       = 1'b0;

        wr_tab[0] = '{addr: 5'd9,  data: 4'hA, high_cycles: 20, bounce: 1'b0};
        wr_tab[1] = '{addr: 5'd17, data: 4'h5, high_cycles: 10, bounce: 1'b1};
        wr_tab[2] = '{addr: 5'd31, data: 4'hC, high_cycles: 10, bounce: 1'b0};
        tk_tab[0] = '{width: 5, exp_rd: 5'd31, exp_wrap: 1'b0};
        tk_tab[1] = '{width: 5, exp_rd: 5'd0,  exp_wrap: 1'b1};
        tk_tab[2] = '{width: 5, exp_rd: 5'd1,  exp_wrap: 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_outputs", {wren, wraddress, data, rdaddress, wrap, holding}, '0);

        // Reset in the middle of the press debounce discards it
        @(posedge clk); #1;
        wr_addr_in = 5'd7;
        wr_data_in = 4'h3;
        wr_req_in  = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mid_outputs", {wren, wraddress, data, rdaddress, wrap, holding}, '0);
        @(posedge clk); #1;
        reset     = 1'b0;
        wr_req_in = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("rst_no_wren", wren_count, 0);
        check("rst_after_outputs", {wraddress, data, holding}, '0);

        // Scan up to 30 with narrow ticks
        for (int i = 0; i < 30; i++) tick_pulse(1);
        check("scan_to_30", {wrap, rdaddress}, {1'b0, 5'd30});

        // Wide tick pulses across the wrap
        for (int i = 0; i < 3; i++) begin
            tick_pulse(tk_tab[i].width);
            check($sformatf("wide_tick%0d_rd", i), rdaddress, tk_tab[i].exp_rd);
            check($sformatf("wide_tick%0d_wrap", i), wrap, tk_tab[i].exp_wrap);
        end
        model_wrap = 1'b1;

        // Writes followed by the two hold ticks
        for (int i = 0; i < 3; i++) begin
            do_write(wr_tab[i].addr, wr_tab[i].data, wr_tab[i].high_cycles, wr_tab[i].bounce,
                     1'b0, $sformatf("wr%0d", i));
            tick_pulse(1);
            check($sformatf("wr%0d_hold_tick1", i), {holding, rdaddress}, {1'b1, wr_tab[i].addr});
            tick_pulse(1);
            nxt = wr_tab[i].addr + 5'd1;
            check($sformatf("wr%0d_exit_rd", i), rdaddress, nxt);
            check($sformatf("wr%0d_exit_holding", i), holding, 1'b0);
            check($sformatf("wr%0d_exit_wrap", i), wrap, model_wrap);
        end

        // Two-cycle glitch on the request is rejected
        base = wren_count;
        @(posedge clk); #1 wr_req_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 wr_req_in = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("glitch_no_wren", wren_count - base, 0);
        check("glitch_scan_kept", {holding, rdaddress}, {1'b0, 5'd0});

        // wren coincident with a tick rise: tick dropped, hold needs two more ticks
        do_write(5'd20, 4'h6, 10, 1'b0, 1'b1, "coinc");
        tick_pulse(1);
        check("coinc_tick1_parked", {holding, rdaddress}, {1'b1, 5'd20});

        // Second write during the hold restarts it on the new address
        do_write(5'd3, 4'h9, 10, 1'b0, 1'b0, "rewr");
        tick_pulse(1);
        check("rewr_tick1_parked", {holding, rdaddress}, {1'b1, 5'd3});
        tick_pulse(1);
        check("rewr_exit", {wrap, holding, rdaddress}, {model_wrap, 1'b0, 5'd4});
        tick_pulse(1);
        check("rewr_scan_resumed", rdaddress, 5'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
